// File: rtl/lmsm_sequencer_if.sv
// rtl/lmsm_sequencer_if.sv - decode-side bundle between IF/ID, the LM/SM sequencer and ID/RR
interface lmsm_sequencer_if;
  logic [15:0] Inst;
  logic        valid_in;
  logic        hold;
  logic        flush;
  logic [2:0]  LM_RegRd;
  logic [15:0] mem_offset;
  logic        valid_out;
  logic        is_store;
  logic        uop_last;
  logic        seq_busy;

  modport master (
    output Inst, valid_in, hold, flush,
    input  LM_RegRd, mem_offset, valid_out, is_store, uop_last, seq_busy
  );

  modport slave (
    input  Inst, valid_in, hold, flush,
    output LM_RegRd, mem_offset, valid_out, is_store, uop_last, seq_busy
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - expands LM/SM register lists into one micro-op per set bit
// Outputs are combinational so the first micro-op leaves in the same cycle as the instruction.
module lmsm_sequencer (
  input  logic               clock,
  input  logic               reset,
  lmsm_sequencer_if.slave    bus
);

  typedef enum logic {IDLE, SEQ} state_t;

  state_t      state, state_n;
  logic [7:0]  mask, mask_n;
  logic [2:0]  count, count_n;
  logic        op_st, op_st_n;

  logic [7:0]  active;
  logic [7:0]  active_rest;
  logic [2:0]  idx;
  logic        single;
  logic        multi;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mask  <= 8'd0;
      count <= 3'd0;
      op_st <= 1'b0;
    end else begin
      state <= state_n;
      mask  <= mask_n;
      count <= count_n;
      op_st <= op_st_n;
    end
  end

  // The stalled IF/ID still holds the instruction in SEQ, so only the mask matters there.
  always_comb begin
    active      = (state == SEQ) ? mask : bus.Inst[7:0];
    active_rest = active & (active - 8'd1);
    single      = (active != 8'd0) && (active_rest == 8'd0);
    multi       = bus.valid_in && (bus.Inst[15:13] == 3'b011);
    idx         = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) idx = 3'(i);
    end
  end

  always_comb begin
    state_n        = state;
    mask_n         = mask;
    count_n        = count;
    op_st_n        = op_st;
    bus.LM_RegRd   = 3'd0;
    bus.mem_offset = 16'd0;
    bus.valid_out  = 1'b0;
    bus.is_store   = 1'b0;
    bus.uop_last   = 1'b1;
    bus.seq_busy   = 1'b0;

    case (state)
      IDLE: begin
        if (!multi) begin
          bus.valid_out = bus.valid_in;
        end else if (active != 8'd0) begin
          bus.LM_RegRd  = idx;
          bus.valid_out = 1'b1;
          bus.is_store  = bus.Inst[12];
          if (!single) begin
            bus.uop_last = 1'b0;
            bus.seq_busy = 1'b1;
            if (!bus.hold) begin
              mask_n  = active_rest;
              count_n = 3'd1;
              op_st_n = bus.Inst[12];
              state_n = SEQ;
            end
          end
        end
      end
      SEQ: begin
        bus.LM_RegRd   = idx;
        bus.mem_offset = {13'd0, count};
        bus.valid_out  = 1'b1;
        bus.is_store   = op_st;
        bus.uop_last   = single;
        bus.seq_busy   = !single;
        if (!bus.hold) begin
          mask_n  = active_rest;
          count_n = count + 3'd1;
          if (single) begin
            state_n = IDLE;
            mask_n  = 8'd0;
            count_n = 3'd0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A flush overrides hold and kills whatever micro-op is on the outputs.
    if (bus.flush) begin
      state_n       = IDLE;
      mask_n        = 8'd0;
      count_n       = 3'd0;
      bus.valid_out = 1'b0;
      bus.seq_busy  = 1'b0;
    end
  end

endmodule
